// File: rtl/rvv_backend_alu_issue_pkg.sv
// Shared types and default sizes for the ALU issue controller.
//   ALU_RS_t : one reservation-station entry as seen by an ALU unit
//   PU2ROB_t : one processing-unit result written back to the ROB
package rvv_backend_alu_issue_pkg;

    localparam int unsigned NUM_ALU_DEFAULT = 2;
    localparam int unsigned PERF_W_DEFAULT  = 16;
    localparam int unsigned ROB_IDX_W       = 5;

    typedef struct packed {
        logic [5:0]           funct6;
        logic [ROB_IDX_W-1:0] rob_entry;
        logic [31:0]          vs1;
        logic [31:0]          vs2;
    } ALU_RS_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_entry;
        logic [31:0]          w_data;
    } PU2ROB_t;

endpackage

// File: rtl/rvv_backend_alu_issue_if.sv
// Bus bundle around the ALU issue controller: RS head entries and pops, ALU unit
// drive and results, and the registered ROB write-back handshake.
//   slave  : the issue controller
//   master : its environment (RS, ALU units, ROB)
interface rvv_backend_alu_issue_if
    import rvv_backend_alu_issue_pkg::*;
#(
    parameter int unsigned NUM_ALU = NUM_ALU_DEFAULT
);
    logic    [NUM_ALU-1:0] rs2alu_uop_valid;
    ALU_RS_t [NUM_ALU-1:0] rs2alu_uop;
    logic    [NUM_ALU-1:0] pop_alu2rs;
    logic    [NUM_ALU-1:0] alu_uop_valid;
    ALU_RS_t [NUM_ALU-1:0] alu_uop;
    logic    [NUM_ALU-1:0] alu_result_valid;
    PU2ROB_t [NUM_ALU-1:0] alu_result;
    logic    [NUM_ALU-1:0] result_valid_alu2rob;
    PU2ROB_t [NUM_ALU-1:0] result_alu2rob;
    logic    [NUM_ALU-1:0] result_ready_rob2alu;

    modport slave (
        input  rs2alu_uop_valid, rs2alu_uop, alu_result_valid, alu_result, result_ready_rob2alu,
        output pop_alu2rs, alu_uop_valid, alu_uop, result_valid_alu2rob, result_alu2rob
    );

    modport master (
        output rs2alu_uop_valid, rs2alu_uop, alu_result_valid, alu_result, result_ready_rob2alu,
        input  pop_alu2rs, alu_uop_valid, alu_uop, result_valid_alu2rob, result_alu2rob
    );
endinterface

// File: rtl/rvv_backend_alu_issue_lane.sv
// One ALU lane: output register towards the ROB, lane-free computation and a
// sticky flag for popped uops that produced no result.
//   clk, rst              : clock, synchronous active-high reset
//   pop_i                 : this lane's uop is consumed this cycle
//   alu_result_valid_i/_i : combinational ALU unit result
//   ready_i               : ROB accepts this lane
//   free_o                : register can take a new result this cycle
//   result_valid_o/_o     : registered result to the ROB
//   err_o                 : sticky illegal-uop flag
module rvv_backend_alu_issue_lane
    import rvv_backend_alu_issue_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    pop_i,
    input  logic    alu_result_valid_i,
    input  PU2ROB_t alu_result_i,
    input  logic    ready_i,
    output logic    free_o,
    output logic    result_valid_o,
    output PU2ROB_t result_o,
    output logic    err_o
);

    logic    valid_q, valid_d;
    PU2ROB_t result_q, result_d;
    logic    err_q, err_d;

    // Draining and refilling in the same cycle is allowed, so a full lane whose
    // result leaves this cycle counts as free.
    assign free_o = ~valid_q | ready_i;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        err_d    = err_q;
        if (pop_i) begin
            valid_d  = alu_result_valid_i;
            result_d = alu_result_i;
            if (!alu_result_valid_i) begin
                err_d = 1'b1;
            end
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign result_valid_o = valid_q;
    assign result_o       = result_q;
    assign err_o          = err_q;

endmodule

// File: rtl/rvv_backend_alu_issue.sv
// Issue controller between the ALU reservation station and NUM_ALU combinational
// ALU units. Pops up to NUM_ALU uops per cycle in RS order, registers each unit's
// result per lane and presents it to the ROB with valid/ready.
//   clk, rst        : clock, synchronous active-high reset
//   bus             : RS / ALU / ROB signals (slave side)
//   illegal_uop_err : sticky, a popped uop produced no ALU result
//   stall_cnt       : saturating count of cycles where the oldest RS entry was
//                     valid but not popped
module rvv_backend_alu_issue
    import rvv_backend_alu_issue_pkg::*;
#(
    parameter int unsigned NUM_ALU = NUM_ALU_DEFAULT,
    parameter int unsigned PERF_W  = PERF_W_DEFAULT
)
(
    input  logic                    clk,
    input  logic                    rst,
    rvv_backend_alu_issue_if.slave  bus,
    output logic                    illegal_uop_err,
    output logic [PERF_W-1:0]       stall_cnt
);

    logic    [NUM_ALU-1:0] pop;
    logic    [NUM_ALU-1:0] lane_free;
    logic    [NUM_ALU-1:0] lane_valid;
    logic    [NUM_ALU-1:0] lane_err;
    PU2ROB_t [NUM_ALU-1:0] lane_result;
    logic    [PERF_W-1:0]  stall_cnt_q, stall_cnt_d;

    // Each entry pops only if every older entry pops too, keeping RS order.
    always_comb begin
        logic chain;
        pop   = '0;
        chain = ~rst;
        for (int i = 0; i < int'(NUM_ALU); i++) begin
            pop[i] = bus.rs2alu_uop_valid[i] & lane_free[i] & chain;
            chain  = pop[i];
        end
    end

    assign bus.pop_alu2rs    = pop;
    assign bus.alu_uop_valid = pop;
    assign bus.alu_uop       = bus.rs2alu_uop;

    for (genvar i = 0; i < NUM_ALU; i++) begin : g_lane
        rvv_backend_alu_issue_lane u_lane (
            .clk                (clk),
            .rst                (rst),
            .pop_i              (pop[i]),
            .alu_result_valid_i (bus.alu_result_valid[i]),
            .alu_result_i       (bus.alu_result[i]),
            .ready_i            (bus.result_ready_rob2alu[i]),
            .free_o             (lane_free[i]),
            .result_valid_o     (lane_valid[i]),
            .result_o           (lane_result[i]),
            .err_o              (lane_err[i])
        );
    end

    assign bus.result_valid_alu2rob = lane_valid;
    assign bus.result_alu2rob       = lane_result;
    assign illegal_uop_err          = |lane_err;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.rs2alu_uop_valid[0] && !pop[0] && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
